stack_catcher: RTL and testbench

Consumer end of the falling-item position stream in the Sky Stacker game. Samples the falling item's position and color on each fall step and compares it against the player platform and the current stack top. It classifies each landing as a catch or a miss and maintains stack height, stacked colors, score, miss count and game-over. It then requests a respawn from the falling-item block through a req/ack handshake.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_catcher_if.sv | 23 ++
 rtl/stack_catcher_color_stack.sv | 44 ++++
 rtl/stack_catcher.sv | 144 ++++++++++++++
 tb/tb_stack_catcher.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared Sky Stacker definitions: catcher state encoding, color width and
// default playfield geometry used by falling_item, the catcher and the renderer.
package stack_pkg;

    localparam int COLOR_W = 2;

    localparam int DEF_ITEM_W     = 32;
    localparam int DEF_ITEM_H     = 16;
    localparam int DEF_PLAYER_W   = 64;
    localparam int DEF_PLATFORM_Y = 440;
    localparam int DEF_GROUND_Y   = 480;
    localparam int DEF_MAX_STACK  = 8;
    localparam int DEF_MISS_LIMIT = 3;

    typedef enum logic [2:0] {
        TRACK    = 3'd0,
        CATCH    = 3'd1,
        MISS     = 3'd2,
        WAIT_ACK = 3'd3,
        OVER     = 3'd4
    } state_e;

endpackage

// File: rtl/stack_catcher_if.sv
// Falling-item stream between falling_item (master) and stack_catcher (slave):
// per-step position/color plus the respawn req/ack handshake.
interface stack_catcher_if;
    import stack_pkg::*;

    logic               fall_tick;
    logic [9:0]         item_x;
    logic [9:0]         item_y;
    logic [COLOR_W-1:0] item_color;
    logic               respawn_req;
    logic               respawn_ack;

    modport master (
        output fall_tick, item_x, item_y, item_color, respawn_ack,
        input  respawn_req
    );

    modport slave (
        input  fall_tick, item_x, item_y, item_color, respawn_ack,
        output respawn_req
    );

endinterface

// File: rtl/stack_catcher_color_stack.sv
// LIFO of stacked item colors. Clear wins over push; top reads 0 when empty
// so the renderer needs no separate empty flag.
module color_stack
    import stack_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_STACK,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               clear_i,
    input  logic [COLOR_W-1:0] data_i,
    output logic [COLOR_W-1:0] top_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][COLOR_W-1:0] mem_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [IDX_W-1:0]              wr_idx;
    logic [IDX_W-1:0]              rd_idx;

    assign wr_idx = IDX_W'(cnt_q);
    assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            mem_q <= '0;
            cnt_q <= '0;
        end else if (push_i && (cnt_q < CNT_W'(DEPTH))) begin
            mem_q[wr_idx] <= data_i;
            cnt_q         <= cnt_q + CNT_W'(1);
        end
    end

    assign top_o   = (cnt_q == '0) ? '0 : mem_q[rd_idx];
    assign count_o = cnt_q;

endmodule

// File: rtl/stack_catcher.sv
// Consumer of the falling-item stream: classifies each landing as catch or
// miss, keeps stack/score/miss bookkeeping and requests a respawn.
module stack_catcher
    import stack_pkg::*;
#(
    parameter int ITEM_W     = DEF_ITEM_W,
    parameter int ITEM_H     = DEF_ITEM_H,
    parameter int PLAYER_W   = DEF_PLAYER_W,
    parameter int PLATFORM_Y = DEF_PLATFORM_Y,
    parameter int GROUND_Y   = DEF_GROUND_Y,
    parameter int MAX_STACK  = DEF_MAX_STACK,
    parameter int MISS_LIMIT = DEF_MISS_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    stack_catcher_if.slave     bus,
    input  logic               pause_i,
    input  logic [9:0]         player_x_i,
    output logic               catch_pulse_o,
    output logic               miss_pulse_o,
    output logic               level_up_o,
    output logic [3:0]         stack_height_o,
    output logic [COLOR_W-1:0] top_color_o,
    output logic [7:0]         score_o,
    output logic [1:0]         misses_o,
    output logic               game_over_o
);

    localparam int CNT_W = $clog2(MAX_STACK + 1);

    state_e             state_q, state_d;
    logic [7:0]         score_q, score_d;
    logic [1:0]         misses_q, misses_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic [CNT_W-1:0]   height;
    logic               push, clear;
    logic               catch_p, miss_p, lvl_p, req, over;
    logic               active;
    logic [10:0]        bottom, stack_top, xl, pl;
    logic               overlap, landed, grounded;
    logic [1:0]         misses_inc;

    assign active = !pause_i;

    // All geometry in 11 bits so item_y + ITEM_H cannot wrap near the ground line.
    assign bottom    = {1'b0, bus.item_y} + 11'(ITEM_H);
    assign stack_top = 11'(PLATFORM_Y) - 11'(height) * 11'(ITEM_H);
    assign xl        = {1'b0, bus.item_x};
    assign pl        = {1'b0, player_x_i};
    assign overlap   = (xl + 11'(ITEM_W) > pl) && (xl < pl + 11'(PLAYER_W));
    assign landed    = bottom >= stack_top;
    assign grounded  = bottom >= 11'(GROUND_Y);
    assign misses_inc = misses_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        misses_d = misses_q;
        color_d  = color_q;
        catch_p  = 1'b0;
        miss_p   = 1'b0;
        lvl_p    = 1'b0;
        push     = 1'b0;
        clear    = 1'b0;
        req      = 1'b0;
        over     = 1'b0;
        case (state_q)
            TRACK: begin
                if (bus.fall_tick && active) begin
                    color_d = bus.item_color;
                    if (landed && overlap) state_d = CATCH;
                    else if (grounded)     state_d = MISS;
                end
            end
            CATCH: begin
                // Paused pulse states hold; the pulse fires on the first free cycle.
                if (active) begin
                    catch_p = 1'b1;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    if (height == CNT_W'(MAX_STACK - 1)) begin
                        clear = 1'b1;
                        lvl_p = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    state_d = WAIT_ACK;
                end
            end
            MISS: begin
                if (active) begin
                    miss_p   = 1'b1;
                    misses_d = misses_inc;
                    state_d  = (misses_inc == 2'(MISS_LIMIT)) ? OVER : WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                req = 1'b1;
                if (active && bus.respawn_ack) state_d = TRACK;
            end
            OVER: begin
                over = 1'b1;
            end
            default: state_d = TRACK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= TRACK;
            score_q  <= '0;
            misses_q <= '0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            color_q  <= color_d;
        end
    end

    color_stack #(
        .DEPTH (MAX_STACK),
        .CNT_W (CNT_W)
    ) u_color_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .clear_i (clear),
        .data_i  (color_q),
        .top_o   (top_color_o),
        .count_o (height)
    );

    assign bus.respawn_req = req;
    assign catch_pulse_o   = catch_p;
    assign miss_pulse_o    = miss_p;
    assign level_up_o      = lvl_p;
    assign stack_height_o  = 4'(height);
    assign score_o         = score_q;
    assign misses_o        = misses_q;
    assign game_over_o     = over;

endmodule

// File: tb/tb_stack_catcher.sv
// Directed bench for stack_catcher: catch, edge miss, game over, full stack,
// pause and asynchronous reset, with hand-computed expectations.
module tb_stack_catcher;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic [9:0] player_x = 10'd300;
    logic       catch_pulse, miss_pulse, level_up, game_over;
    logic [3:0] stack_height;
    logic [1:0] top_color, misses;
    logic [7:0] score;
    int         n_chk = 0;
    int         n_err = 0;

    stack_catcher_if sif ();

    stack_catcher dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (sif),
        .pause_i        (pause),
        .player_x_i     (player_x),
        .catch_pulse_o  (catch_pulse),
        .miss_pulse_o   (miss_pulse),
        .level_up_o     (level_up),
        .stack_height_o (stack_height),
        .top_color_o    (top_color),
        .score_o        (score),
        .misses_o       (misses),
        .game_over_o    (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Presents one fall step; returns at the negedge of the cycle after the tick edge.
    task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic [1:0] c);
        sif.item_x     = x;
        sif.item_y     = y;
        sif.item_color = c;
        sif.fall_tick  = 1'b1;
        @(negedge clk);
        sif.fall_tick  = 1'b0;
    endtask

    task automatic ack();
        sif.respawn_ack = 1'b1;
        @(negedge clk);
        sif.respawn_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] y;
        logic [1:0] c;
        sif.fall_tick   = 1'b0;
        sif.item_x      = '0;
        sif.item_y      = '0;
        sif.item_color  = '0;
        sif.respawn_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", sif.respawn_req, 0);
        chk("rst_height", stack_height, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_over", game_over, 0);
        chk("rst_top", top_color, 0);
        chk("rst_pulses", {catch_pulse, miss_pulse, level_up}, 0);
        rst = 1'b0;
        @(negedge clk);

        // One pixel above the platform line: nothing happens
        tick(10'd310, 10'd423, 2'd2);
        chk("short_catch", catch_pulse, 0);
        chk("short_miss", miss_pulse, 0);

        tick(10'd310, 10'd424, 2'd2);
        chk("c1_pulse", catch_pulse, 1);
        chk("c1_level", level_up, 0);
        @(negedge clk);
        chk("c1_height", stack_height, 1);
        chk("c1_score", score, 1);
        chk("c1_top", top_color, 2);
        chk("c1_req", sif.respawn_req, 1);
        @(negedge clk);
        chk("c1_req_hold", sif.respawn_req, 1);
        ack();
        chk("c1_req_drop", sif.respawn_req, 0);

        // Edge-touching on the right is not overlap
        player_x = 10'd342;
        tick(10'd310, 10'd424, 2'd1);
        chk("edge_catch", catch_pulse, 0);
        chk("edge_miss", miss_pulse, 0);
        tick(10'd310, 10'd464, 2'd1);
        chk("m1_pulse", miss_pulse, 1);
        @(negedge clk);
        chk("m1_misses", misses, 1);
        chk("m1_req", sif.respawn_req, 1);
        chk("m1_height", stack_height, 1);
        ack();

        tick(10'd310, 10'd464, 2'd0);
        chk("m2_pulse", miss_pulse, 1);
        @(negedge clk);
        chk("m2_misses", misses, 2);
        ack();
        tick(10'd310, 10'd464, 2'd0);
        chk("m3_pulse", miss_pulse, 1);
        chk("m3_over_early", game_over, 0);
        @(negedge clk);
        chk("m3_over", game_over, 1);
        chk("m3_misses", misses, 3);
        chk("m3_req", sif.respawn_req, 0);
        sif.respawn_ack = 1'b1;
        tick(10'd310, 10'd464, 2'd0);
        chk("over_quiet", {catch_pulse, miss_pulse}, 0);
        @(negedge clk);
        chk("over_sticky", game_over, 1);
        chk("over_noreq", sif.respawn_req, 0);
        sif.respawn_ack = 1'b0;

        rst = 1'b1;
        #1;
        chk("rst2_over", game_over, 0);
        chk("rst2_misses", misses, 0);
        chk("rst2_score", score, 0);
        chk("rst2_height", stack_height, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fill the stack; each item lands exactly on the current stack top
        player_x = 10'd300;
        for (int h = 0; h < 8; h++) begin
            y = 10'(424 - 16 * h);
            c = 2'(h + 1);
            if (h == 1) begin
                tick(10'd310, y - 10'd1, c);
                chk("fill_short", catch_pulse, 0);
            end
            tick(10'd310, y, c);
            chk($sformatf("fill%0d_pulse", h), catch_pulse, 1);
            chk($sformatf("fill%0d_level", h), level_up, (h == 7) ? 1 : 0);
            @(negedge clk);
            chk($sformatf("fill%0d_height", h), stack_height, (h == 7) ? 0 : h + 1);
            chk($sformatf("fill%0d_top", h), top_color, (h == 7) ? 0 : 32'(c));
            ack();
        end
        chk("fill_score", score, 8);

        // Paused landing tick is ignored
        pause = 1'b1;
        tick(10'd310, 10'd424, 2'd2);
        chk("pause_tick", catch_pulse, 0);
        @(negedge clk);
        chk("pause_height", stack_height, 0);
        pause = 1'b0;
        #1;
        chk("pause_release", catch_pulse, 0);
        @(negedge clk);

        // Pause caught inside CATCH holds the pulse until release
        tick(10'd310, 10'd424, 2'd3);
        pause = 1'b1;
        #1;
        chk("hold_pulse0", catch_pulse, 0);
        repeat (2) @(negedge clk);
        chk("hold_pulse1", catch_pulse, 0);
        chk("hold_score", score, 8);
        pause = 1'b0;
        #1;
        chk("hold_fire", catch_pulse, 1);
        @(negedge clk);
        chk("hold_score_inc", score, 9);
        chk("hold_height", stack_height, 1);
        chk("hold_top", top_color, 3);
        chk("hold_req", sif.respawn_req, 1);

        // Asynchronous reset in the middle of the handshake
        rst = 1'b1;
        #1;
        chk("arst_req", sif.respawn_req, 0);
        chk("arst_score", score, 0);
        chk("arst_height", stack_height, 0);
        chk("arst_top", top_color, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
